instr_encoder_loader: RTL

- Encoder counterpart of the single-cycle controller's decoder: accepts abstract instruction descriptors, encodes them into 32-bit MIPS machine words, and writes them sequentially into instruction memory.
- Input is a valid/ready stream, output an IM write port; a small FIFO decouples them.
- Used for self-loading test programs and for bench-side instruction generation.

---
 rtl/instr_encoder_loader_pkg.sv | 73 +++++++
 rtl/instr_encoder_loader_fifo.sv | 54 +++++
 rtl/instr_encoder_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// instr_encoder_loader_pkg
//   Shared definitions for the instruction encoder/loader: the abstract op
//   enum, MIPS opcode/funct constants (kept identical to the controller's
//   decode constants), loader FSM states, and the combinational encoder.
package instr_encoder_loader_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_ORI = 4'd3,
    OP_LW  = 4'd4,
    OP_SW  = 4'd5,
    OP_BEQ = 4'd6,
    OP_LUI = 4'd7,
    OP_JAL = 4'd8,
    OP_J   = 4'd9,
    OP_JR  = 4'd10
  } op_e;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_J       = 6'b000010;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_JR    = 6'b001000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_PAD,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] word;
  } enc_t;

  // Ops 11..15 come back with valid=0 and a zero word.
  function automatic enc_t encode(input logic [3:0]  op,
                                  input logic [4:0]  rs,
                                  input logic [4:0]  rt,
                                  input logic [4:0]  rd,
                                  input logic [25:0] imm);
    enc_t e;
    e.valid = 1'b1;
    e.word  = '0;
    case (op_e'(op))
      OP_NOP: e.word = '0;
      OP_ADD: e.word = {OPC_SPECIAL, rs, rt, rd, 5'b00000, FUNCT_ADD};
      OP_SUB: e.word = {OPC_SPECIAL, rs, rt, rd, 5'b00000, FUNCT_SUB};
      OP_ORI: e.word = {OPC_ORI, rs, rt, imm[15:0]};
      OP_LW:  e.word = {OPC_LW,  rs, rt, imm[15:0]};
      OP_SW:  e.word = {OPC_SW,  rs, rt, imm[15:0]};
      OP_BEQ: e.word = {OPC_BEQ, rs, rt, imm[15:0]};
      OP_LUI: e.word = {OPC_LUI, 5'b00000, rt, imm[15:0]};
      OP_JAL: e.word = {OPC_JAL, imm};
      OP_J:   e.word = {OPC_J,   imm};
      OP_JR:  e.word = {OPC_SPECIAL, rs, 15'b0, FUNCT_JR};
      default: e.valid = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_fifo.sv
// instr_fifo
//   Synchronous DEPTH x WIDTH FIFO with full/empty flags, async active-high
//   reset. DEPTH must be a power of two >= 2. Push while full and pop while
//   empty are ignored; a pop in the same cycle does not make room for a push
//   when full.
// Ports:
//   clk, rst          clock, async reset
//   i_push, i_wdata   write side
//   i_pop, o_rdata    read side (o_rdata is the current head)
//   o_full, o_empty   status flags
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr[AW-1:0]] <= i_wdata;
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop_ok) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Accepts abstract instruction descriptors on a valid/ready stream, encodes
//   them into 32-bit MIPS words and writes them sequentially into instruction
//   memory starting at BASE_ADDR, via a DEPTH-entry FIFO.
//   Optional: define INSTR_ENCODER_PAD_NOP_EN to pad the program with NOP
//   words until word_count is a multiple of 4 before reporting done.
// Ports:
//   clk, reset                       clock, async active-high reset
//   in_valid/in_ready                descriptor handshake
//   in_op/in_rs/in_rt/in_rd/in_imm   descriptor fields
//   in_last                          final descriptor of the program
//   im_we/im_ready                   IM write handshake
//   im_addr/im_wdata                 IM write address / encoded word
//   word_count                       words written so far
//   done                             program fully written (sticky)
//   err                              invalid op or capacity overflow (sticky)
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [25:0] in_imm,
  input  logic        in_last,
  output logic        im_we,
  input  logic        im_ready,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic [10:0] word_count,
  output logic        done,
  output logic        err
);
  localparam logic [10:0] W_MAX = 11'(MAX_WORDS);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_addr;
  logic [10:0] r_word_count;
  logic        r_err;

  enc_t        w_enc;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_cap_full;
  logic        w_head_avail;
  logic        w_pad_emit;
  logic        w_wr_ok;
  logic        w_err_set;
  logic        w_in_ready;
  logic        w_im_we;
  logic [31:0] w_im_wdata;

  assign w_enc      = encode(in_op, in_rs, in_rt, in_rd, in_imm);
  assign w_cap_full = (r_word_count == W_MAX);

  instr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .i_push (w_push),
    .i_wdata(w_enc.word),
    .i_pop  (w_pop),
    .o_rdata(w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_in_ready   = !w_full && (r_state == ST_IDLE || r_state == ST_LOAD);
    w_accept     = in_valid && w_in_ready;
    w_push       = w_accept && w_enc.valid;
    w_head_avail = !w_empty && (r_state == ST_LOAD || r_state == ST_DRAIN);
    w_pad_emit   = 1'b0;
    w_im_wdata   = w_head;
`ifdef INSTR_ENCODER_PAD_NOP_EN
    w_pad_emit   = (r_state == ST_PAD) && (r_word_count[1:0] != 2'b00);
    if (r_state == ST_PAD) w_im_wdata = '0;
`endif
    // At capacity the head is still consumed, but never offered to IM.
    w_im_we      = (w_head_avail || w_pad_emit) && !w_cap_full;
    w_pop        = w_head_avail && (w_cap_full || im_ready);
    w_wr_ok      = w_im_we && im_ready;
    w_err_set    = (w_accept && !w_enc.valid) ||
                   ((w_head_avail || w_pad_emit) && w_cap_full);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = in_last ? ST_DRAIN : ST_LOAD;
      ST_LOAD:  if (w_accept && in_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (w_empty) begin
          w_state_nxt = ST_DONE;
`ifdef INSTR_ENCODER_PAD_NOP_EN
          if (r_word_count[1:0] != 2'b00 && !w_cap_full) w_state_nxt = ST_PAD;
`endif
        end
      end
      ST_PAD:   if (r_word_count[1:0] == 2'b00 || w_cap_full) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= BASE_ADDR;
      r_word_count <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_ok) begin
        r_addr       <= r_addr + 32'd4;
        r_word_count <= r_word_count + 11'd1;
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign in_ready   = w_in_ready;
  assign im_we      = w_im_we;
  assign im_addr    = r_addr;
  assign im_wdata   = w_im_wdata;
  assign word_count = r_word_count;
  assign done       = (r_state == ST_DONE);
  assign err        = r_err;

endmodule
